// File: rtl/color_gradient_anim.sv
// Animated RGB gradient: exact start->end interpolation, one step per tick, one-shot/wrap/ping-pong.
// Define COLOR_GRADIENT_PINGPONG_EN to build ping-pong (mode 2); otherwise mode 2 wraps like mode 1.
module color_gradient_anim #(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned STEP_W  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [3*COLOR_W-1:0] i_cfg_start,
  input  logic [3*COLOR_W-1:0] i_cfg_end,
  input  logic [1:0]           i_cfg_mode,
  input  logic                 i_tick,
  output logic [STEP_W-1:0]    o_step,
  output logic [COLOR_W-1:0]   o_r,
  output logic [COLOR_W-1:0]   o_g,
  output logic [COLOR_W-1:0]   o_b,
  output logic                 o_out_valid,
  output logic                 o_at_end
);

  localparam logic [STEP_W-1:0] MAX      = {STEP_W{1'b1}};
  localparam int unsigned       CNT_W    = $clog2(COLOR_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COLOR_W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                   r_state, w_state_next;
  logic [2:0][COLOR_W-1:0]  r_start, r_col, r_q;
  logic [2:0][STEP_W-1:0]   r_rem, r_err;
  logic [2:0]               r_neg;
  logic [1:0]               r_mode;
  logic [STEP_W-1:0]        r_step;
  logic [CNT_W-1:0]         r_cnt;

  logic                     w_hs, w_fwd, w_bwd, w_reload;
  logic [2:0][COLOR_W-1:0]  w_cfg_start, w_cfg_end, w_abs, w_div_q, w_fwd_col;
  logic [2:0][STEP_W-1:0]   w_div_rem, w_fwd_err;
  logic [2:0][STEP_W:0]     w_shift, w_acc;
  logic [2:0]               w_cfg_neg, w_carry;
`ifdef COLOR_GRADIENT_PINGPONG_EN
  logic                     r_dir_down;
  logic [2:0][COLOR_W-1:0]  w_bwd_col;
  logic [2:0][STEP_W-1:0]   w_bwd_err;
  logic [2:0]               w_borrow;
`endif

  assign w_cfg_start = i_cfg_start;
  assign w_cfg_end   = i_cfg_end;
  assign w_hs        = i_cfg_valid & o_cfg_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = StLoad;
      StLoad:  if (r_cnt == CNT_LAST) w_state_next = StRun;
      StRun:   if (w_hs) w_state_next = StLoad;
      default: w_state_next = StIdle;
    endcase
  end

  // Per-channel arithmetic: one restoring-divide step, and forward/backward Bresenham-style steps.
  always_comb begin
    w_cfg_neg = '0;
    w_abs     = '0;
    w_shift   = '0;
    w_div_q   = '0;
    w_div_rem = '0;
    w_acc     = '0;
    w_carry   = '0;
    w_fwd_err = '0;
    w_fwd_col = '0;
`ifdef COLOR_GRADIENT_PINGPONG_EN
    w_borrow  = '0;
    w_bwd_err = '0;
    w_bwd_col = '0;
`endif
    for (int c = 0; c < 3; c++) begin
      w_cfg_neg[c] = w_cfg_end[c] < w_cfg_start[c];
      w_abs[c]     = w_cfg_neg[c] ? (w_cfg_start[c] - w_cfg_end[c])
                                  : (w_cfg_end[c] - w_cfg_start[c]);

      w_shift[c]   = {r_rem[c], r_q[c][COLOR_W-1]};
      if (w_shift[c] >= {1'b0, MAX}) begin
        w_div_rem[c] = STEP_W'(w_shift[c] - {1'b0, MAX});
        w_div_q[c]   = {r_q[c][COLOR_W-2:0], 1'b1};
      end else begin
        w_div_rem[c] = w_shift[c][STEP_W-1:0];
        w_div_q[c]   = {r_q[c][COLOR_W-2:0], 1'b0};
      end

      w_acc[c]     = {1'b0, r_err[c]} + {1'b0, r_rem[c]};
      w_carry[c]   = w_acc[c] >= {1'b0, MAX};
      w_fwd_err[c] = w_carry[c] ? STEP_W'(w_acc[c] - {1'b0, MAX}) : w_acc[c][STEP_W-1:0];
      w_fwd_col[c] = r_neg[c] ? (r_col[c] - (r_q[c] + COLOR_W'(w_carry[c])))
                              : (r_col[c] + (r_q[c] + COLOR_W'(w_carry[c])));
`ifdef COLOR_GRADIENT_PINGPONG_EN
      w_borrow[c]  = r_err[c] < r_rem[c];
      w_bwd_err[c] = w_borrow[c] ? (r_err[c] + (MAX - r_rem[c])) : (r_err[c] - r_rem[c]);
      w_bwd_col[c] = r_neg[c] ? (r_col[c] + (r_q[c] + COLOR_W'(w_borrow[c])))
                              : (r_col[c] - (r_q[c] + COLOR_W'(w_borrow[c])));
`endif
    end
  end

  // A config handshake in RUN wins over a simultaneous tick.
  always_comb begin
    w_fwd    = 1'b0;
    w_bwd    = 1'b0;
    w_reload = 1'b0;
    if (r_state == StRun && i_tick && !w_hs && r_mode != 2'd3) begin
`ifdef COLOR_GRADIENT_PINGPONG_EN
      if (r_mode == 2'd2) begin
        if (r_step == MAX || (r_dir_down && r_step != '0)) w_bwd = 1'b1;
        else                                               w_fwd = 1'b1;
      end else
`endif
      if (r_step != MAX)        w_fwd    = 1'b1;
      else if (r_mode != 2'd0)  w_reload = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start <= '0;
      r_col   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_err   <= '0;
      r_neg   <= '0;
      r_mode  <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
    end else if (w_hs) begin
      r_start <= w_cfg_start;
      r_neg   <= w_cfg_neg;
      r_q     <= w_abs;
      r_rem   <= '0;
      r_mode  <= i_cfg_mode;
      r_cnt   <= '0;
    end else if (r_state == StLoad) begin
      r_q   <= w_div_q;
      r_rem <= w_div_rem;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_step <= '0;
        r_col  <= r_start;
        r_err  <= '0;
      end
    end else if (w_fwd) begin
      r_step <= r_step + 1'b1;
      r_col  <= w_fwd_col;
      r_err  <= w_fwd_err;
`ifdef COLOR_GRADIENT_PINGPONG_EN
    end else if (w_bwd) begin
      r_step <= r_step - 1'b1;
      r_col  <= w_bwd_col;
      r_err  <= w_bwd_err;
`endif
    end else if (w_reload) begin
      r_step <= '0;
      r_col  <= r_start;
      r_err  <= '0;
    end
  end

`ifdef COLOR_GRADIENT_PINGPONG_EN
  // Direction simply remembers whether the last move was backward.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                        r_dir_down <= 1'b0;
    else if (r_state == StLoad && r_cnt == CNT_LAST)  r_dir_down <= 1'b0;
    else if (w_fwd || w_bwd)                          r_dir_down <= w_bwd;
  end
`endif

  assign o_step      = r_step;
  assign o_r         = r_col[2];
  assign o_g         = r_col[1];
  assign o_b         = r_col[0];
  assign o_out_valid = (r_state == StRun);
  assign o_cfg_ready = (r_state != StLoad);
  assign o_at_end    = (r_step == MAX);

endmodule

// File: tb/tb_color_gradient_anim.sv
// Directed, table-driven bench for color_gradient_anim (COLOR_W=8, STEP_W=4, MAX=15).
module tb_color_gradient_anim;

  localparam int unsigned COLOR_W = 8;
  localparam int unsigned STEP_W  = 4;
`ifdef COLOR_GRADIENT_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, tick, out_valid, at_end;
  logic [23:0] cfg_start, cfg_end;
  logic [1:0]  cfg_mode;
  logic [3:0]  step;
  logic [7:0]  r, g, b;
  logic [23:0] rgb;

  always #5 clk = ~clk;
  assign rgb = {r, g, b};

  color_gradient_anim #(.COLOR_W(COLOR_W), .STEP_W(STEP_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_start (cfg_start),
    .i_cfg_end   (cfg_end),
    .i_cfg_mode  (cfg_mode),
    .i_tick      (tick),
    .o_step      (step),
    .o_r         (r),
    .o_g         (g),
    .o_b         (b),
    .o_out_valid (out_valid),
    .o_at_end    (at_end)
  );

  typedef struct packed {
    logic [23:0] c_start;
    logic [23:0] c_end;
    logic [1:0]  mode;
    logic [7:0]  nticks;
    logic [3:0]  e_step;
    logic [23:0] e_rgb;
    logic        e_at_end;
  } vec_t;

  vec_t vecs[11];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Handshake in cycle T, then verify the T+1 drop and the T+COLOR_W+1 reveal.
  task automatic load(input logic [23:0] s, input logic [23:0] e, input logic [1:0] m,
                      input int idx);
    cfg_start = s;
    cfg_end   = e;
    cfg_mode  = m;
    cfg_valid = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    chk("load_ov_drop", idx, 32'(out_valid), 32'd0);
    chk("load_ready_low", idx, 32'(cfg_ready), 32'd0);
    repeat (COLOR_W - 1) clk1();
    chk("load_ov_late", idx, 32'(out_valid), 32'd0);
    clk1();
    chk("load_ov_up", idx, 32'(out_valid), 32'd1);
    chk("load_step0", idx, 32'(step), 32'd0);
    chk("load_rgb_start", idx, 32'(rgb), 32'(s));
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) clk1();
    tick = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{24'h00bbee, 24'hff00bb, 2'd0, 8'd1,  4'd1,  24'h11afeb, 1'b0};
    vecs[1]  = '{24'h00bbee, 24'hff00bb, 2'd0, 8'd15, 4'd15, 24'hff00bb, 1'b1};
    vecs[2]  = '{24'h00bbee, 24'hff00bb, 2'd0, 8'd16, 4'd15, 24'hff00bb, 1'b1};
    vecs[3]  = '{24'h00bbee, 24'hff00bb, 2'd1, 8'd16, 4'd0,  24'h00bbee, 1'b0};
    vecs[4]  = '{24'h00bbee, 24'hff00bb, 2'd1, 8'd15, 4'd15, 24'hff00bb, 1'b1};
    vecs[5]  = '{24'h00bbee, 24'hff00bb, 2'd2, 8'd16, PP ? 4'd14 : 4'd0,
                 PP ? 24'hee0dbf : 24'h00bbee, 1'b0};
    vecs[6]  = '{24'h00bbee, 24'hff00bb, 2'd2, 8'd30, PP ? 4'd0 : 4'd14,
                 PP ? 24'h00bbee : 24'hee0dbf, 1'b0};
    vecs[7]  = '{24'h00bbee, 24'hff00bb, 2'd2, 8'd31, PP ? 4'd1 : 4'd15,
                 PP ? 24'h11afeb : 24'hff00bb, !PP};
    vecs[8]  = '{24'h00bbee, 24'hff00bb, 2'd3, 8'd20, 4'd0,  24'h00bbee, 1'b0};
    vecs[9]  = '{24'h123456, 24'h123456, 2'd0, 8'd5,  4'd5,  24'h123456, 1'b0};
    vecs[10] = '{24'hff0000, 24'h00ff10, 2'd0, 8'd7,  4'd7,  24'h887707, 1'b0};

    rst       = 1'b1;
    cfg_valid = 1'b0;
    tick      = 1'b0;
    cfg_start = '0;
    cfg_end   = '0;
    cfg_mode  = '0;
    clk1();
    clk1();
    chk("rst_ov", 0, 32'(out_valid), 32'd0);
    chk("rst_step", 0, 32'(step), 32'd0);
    chk("rst_rgb", 0, 32'(rgb), 32'd0);
    chk("rst_ready", 0, 32'(cfg_ready), 32'd1);
    chk("rst_at_end", 0, 32'(at_end), 32'd0);
    rst = 1'b0;

    // Ticks in IDLE are ignored.
    ticks(3);
    chk("idle_tick_step", 0, 32'(step), 32'd0);

    for (int i = 0; i < 11; i++) begin
      load(vecs[i].c_start, vecs[i].c_end, vecs[i].mode, i);
      ticks(int'(vecs[i].nticks));
      chk("vec_step", i, 32'(step), 32'(vecs[i].e_step));
      chk("vec_rgb", i, 32'(rgb), 32'(vecs[i].e_rgb));
      chk("vec_at_end", i, 32'(at_end), 32'(vecs[i].e_at_end));
      chk("vec_ov", i, 32'(out_valid), 32'd1);
    end

    // cfg_valid held through LOAD with a changed end: second request accepted only at RUN entry.
    cfg_start = 24'h00bbee;
    cfg_end   = 24'hff00bb;
    cfg_mode  = 2'd0;
    cfg_valid = 1'b1;
    tick      = 1'b1;
    clk1();
    cfg_end = 24'h112233;
    chk("hold_ready_low", 0, 32'(cfg_ready), 32'd0);
    repeat (COLOR_W - 1) clk1();
    chk("hold_ov_low", 0, 32'(out_valid), 32'd0);
    clk1();
    chk("hold_ov_up", 0, 32'(out_valid), 32'd1);
    chk("hold_step0", 0, 32'(step), 32'd0);
    chk("hold_rgb", 0, 32'(rgb), 32'h00bbee);
    chk("hold_ready_up", 0, 32'(cfg_ready), 32'd1);
    clk1();
    cfg_valid = 1'b0;
    tick      = 1'b0;
    chk("hold_reload_ov", 0, 32'(out_valid), 32'd0);
    repeat (COLOR_W) clk1();
    chk("hold_run_ov", 0, 32'(out_valid), 32'd1);
    chk("hold_run_step", 0, 32'(step), 32'd0);
    ticks(15);
    chk("hold_new_end", 0, 32'(rgb), 32'h112233);
    chk("hold_at_end", 0, 32'(at_end), 32'd1);

    // Config and tick in the same RUN cycle: tick dropped, reload proceeds.
    load(24'h00bbee, 24'hff00bb, 2'd0, 20);
    ticks(3);
    chk("cfgtick_pre", 0, 32'(step), 32'd3);
    cfg_valid = 1'b1;
    tick      = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    tick      = 1'b0;
    chk("cfgtick_step", 0, 32'(step), 32'd3);
    chk("cfgtick_ov", 0, 32'(out_valid), 32'd0);
    repeat (COLOR_W) clk1();
    chk("cfgtick_run_ov", 0, 32'(out_valid), 32'd1);
    chk("cfgtick_run_step", 0, 32'(step), 32'd0);
    chk("cfgtick_run_rgb", 0, 32'(rgb), 32'h00bbee);

    // Reset mid-LOAD.
    cfg_valid = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    repeat (3) clk1();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("rstload_rgb", 0, 32'(rgb), 32'd0);
    chk("rstload_step", 0, 32'(step), 32'd0);
    chk("rstload_ov", 0, 32'(out_valid), 32'd0);
    chk("rstload_ready", 0, 32'(cfg_ready), 32'd1);

    // Reset mid-RUN at step 7.
    load(24'h00bbee, 24'hff00bb, 2'd0, 21);
    ticks(7);
    chk("rstrun_pre_step", 0, 32'(step), 32'd7);
    chk("rstrun_pre_rgb", 0, 32'(rgb), 32'h7764d7);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("rstrun_rgb", 0, 32'(rgb), 32'd0);
    chk("rstrun_step", 0, 32'(step), 32'd0);
    chk("rstrun_ov", 0, 32'(out_valid), 32'd0);
    chk("rstrun_ready", 0, 32'(cfg_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
